// File: rtl/kaliski_almost_inv.sv
// Kaliski almost-inverse engine: for odd p and 0 < a < p, returns a^-1 * 2^k mod p
// together with the iteration count k, or err when the operands are invalid or share a factor.
module compare_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);
  always_comb begin
    gt = (a > b);
  end
endmodule

module kaliski_almost_inv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [6:0]   k,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

  state_t       state, state_nx;
  logic [W-1:0] a_q, p_q;
  logic [W-1:0] u, v, u_nx, v_nx;
  logic [W:0]   r, s, r_nx, s_nx;
  logic [6:0]   cnt;
  logic         u_gt_v;
  logic         invalid;
  logic         r_ge_p;
  logic [W-1:0] fix_val;

  compare_32bit u_cmp (
    .a  (u),
    .b  (v),
    .gt (u_gt_v)
  );

  always_comb begin
    invalid = ~p_q[0] | (a_q == '0) | (a_q >= p_q);
    r_ge_p  = (r >= {1'b0, p_q});
    // Only the low W bits of 2p-r / p-r are needed, so modular W-bit arithmetic suffices.
    fix_val = r_ge_p ? ((p_q << 1) - r[W-1:0]) : (p_q - r[W-1:0]);
  end

  always_comb begin
    u_nx = u;
    v_nx = v;
    r_nx = r;
    s_nx = s;
    if (!u[0]) begin
      u_nx = u >> 1;
      s_nx = s << 1;
    end else if (!v[0]) begin
      v_nx = v >> 1;
      r_nx = r << 1;
    end else if (u_gt_v) begin
      u_nx = (u - v) >> 1;
      r_nx = r + s;
      s_nx = s << 1;
    end else begin
      v_nx = (v - u) >> 1;
      s_nx = s + r;
      r_nx = r << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Leaving ITER on the step that zeroes v saves the idle v==0 cycle,
  // giving done after edge k+3; the explicit v==0 test is a fallback.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = invalid ? DONE : ITER;
      ITER:    if ((v == '0) || (v_nx == '0)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      p_q    <= '0;
      u      <= '0;
      v      <= '0;
      r      <= '0;
      s      <= '0;
      cnt    <= '0;
      result <= '0;
      k      <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            p_q <= p;
          end
        end
        LOAD: begin
          result <= '0;
          k      <= '0;
          if (invalid) begin
            err <= 1'b1;
          end else begin
            err <= 1'b0;
            u   <= p_q;
            v   <= a_q;
            r   <= '0;
            s   <= {{W{1'b0}}, 1'b1};
            cnt <= '0;
          end
        end
        ITER: begin
          if (v != '0) begin
            u   <= u_nx;
            v   <= v_nx;
            r   <= r_nx;
            s   <= s_nx;
            cnt <= cnt + 7'd1;
          end
        end
        FIX: begin
          k <= cnt;
          if (u != {{(W-1){1'b0}}, 1'b1}) begin
            err    <= 1'b1;
            result <= '0;
          end else begin
            err    <= 1'b0;
            result <= fix_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kaliski_almost_inv.sv
// Bench for kaliski_almost_inv: arithmetic reference model, per-cycle output checker,
// directed vectors pinned to hand-computed values, and a random scoreboard on large odd moduli.
module tb_kaliski_almost_inv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_p;
  logic        busy, done, err;
  logic [31:0] result;
  logic [6:0]  k;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          active = 0;
  int          launch_cyc = 0;
  int          done_at = 0;
  logic [31:0] m_res = '0;
  int          m_k = 0;
  bit          m_err = 0;

  kaliski_almost_inv #(.W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (op_a),
    .p      (op_p),
    .busy   (busy),
    .done   (done),
    .result (result),
    .k      (k),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endfunction

  // Reference: binary extended-gcd formulation with plain integer arithmetic.
  function automatic void ref_model(input longint unsigned ma, input longint unsigned mp,
                                    output longint unsigned res, output int kk,
                                    output bit e, output int lat);
    longint unsigned u, v, r, s;
    res = 0;
    kk  = 0;
    e   = 1;
    lat = 2;
    if ((mp % 2 == 0) || (ma == 0) || (ma >= mp)) return;
    u = mp; v = ma; r = 0; s = 1;
    while (v != 0) begin
      if (u % 2 == 0)      begin u = u / 2; s = s * 2; end
      else if (v % 2 == 0) begin v = v / 2; r = r * 2; end
      else if (u > v)      begin u = (u - v) / 2; r = r + s; s = s * 2; end
      else                 begin v = (v - u) / 2; s = s + r; r = r * 2; end
      kk++;
    end
    e   = (u != 1);
    res = e ? 0 : ((r >= mp) ? (2 * mp - r) : (mp - r));
    lat = kk + 3;
  endfunction

  function automatic longint unsigned gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic longint unsigned pow2mod(input int e, input longint unsigned m);
    longint unsigned x = 1 % m;
    for (int i = 0; i < e; i++) x = (x * 2) % m;
    return x;
  endfunction

  always @(negedge clk) begin
    if (active) begin
      chk("done", done, cyc == done_at);
      chk("busy", busy, (cyc > launch_cyc) && (cyc <= done_at));
      if (cyc >= done_at) begin
        chk("result", result, m_res);
        chk("k", k, m_k);
        chk("err", err, m_err);
      end
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_result", result, 0);
      chk("idle_k", k, 0);
      chk("idle_err", err, 0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] ta, input logic [31:0] tp);
    longint unsigned r;
    int kk, l;
    bit e;
    ref_model(ta, tp, r, kk, e, l);
    m_res      = r[31:0];
    m_k        = kk;
    m_err      = e;
    launch_cyc = cyc;
    done_at    = cyc + l;
    active     = 1;
    op_a       = ta;
    op_p       = tp;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done;
    while (cyc < done_at) step();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] p;
    logic [31:0] res;
    int          k;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs[6] = '{
    '{32'd3, 32'd7, 32'd3, 4, 1'b0, 7},
    '{32'd1, 32'd7, 32'd1, 3, 1'b0, 6},
    '{32'd3, 32'd9, 32'd0, 2, 1'b1, 5},
    '{32'd1, 32'd6, 32'd0, 0, 1'b1, 2},
    '{32'd0, 32'd7, 32'd0, 0, 1'b1, 2},
    '{32'd7, 32'd7, 32'd0, 0, 1'b1, 2}
  };

  initial begin
    longint unsigned mr, g;
    int mk, ml;
    bit me;
    logic [31:0] ta, tp;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_p  = '0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_k", k, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      ref_model(vecs[i].a, vecs[i].p, mr, mk, me, ml);
      chk("model_res", mr, vecs[i].res);
      chk("model_k", mk, vecs[i].k);
      chk("model_err", me, vecs[i].err);
      chk("model_lat", ml, vecs[i].lat);
      launch(vecs[i].a, vecs[i].p);
      wait_done();
      step();
    end

    // Starts during LOAD and ITER must be ignored.
    launch(32'd3, 32'd7);
    op_a = 32'd1; op_p = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    // Start while done is high is dropped; the next IDLE start is taken.
    op_a = 32'd1; op_p = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    launch(32'd1, 32'd7);
    wait_done();
    step();

    // Reset abort at edge 4 of a run.
    launch(32'd3, 32'd7);
    step();
    step();
    step();
    active = 0;
    rst_n  = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_k", k, 0);
    chk("abort_err", err, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    launch(32'd3, 32'd7);
    wait_done();
    chk("post_reset_result", result, 3);
    chk("post_reset_k", k, 4);
    step();

    for (int i = 0; i < 40; i++) begin
      tp = $urandom | 32'h8000_0001;
      if (i < 4) tp = 32'hFFFF_FFFF;
      if (i == 4)      ta = tp - 32'd1;
      else if (i == 5) ta = 32'd1;
      else             ta = $urandom_range(tp - 32'd1, 32'd1);
      launch(ta, tp);
      wait_done();
      g = gcd(ta, tp);
      chk("rnd_err_vs_gcd", err, g != 1);
      if (g == 1) begin
        chk("rnd_congruence", (longint'(result) * longint'(ta)) % tp, pow2mod(int'(k), tp));
        chk("rnd_k_range", (k >= 7'd32) && (k <= 7'd64), 1);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kaliski_almost_inv.md
KALISKI_ALMOST_INV -- requirements
Module: kaliski_almost_inv

Interface
REQ-001 The block SHALL have parameter W, default 32, the operand width; only W=32 is supported, matching compare_32bit.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin an inversion.
REQ-005 The block SHALL have port a, input, 32, the operand to invert; it is sampled with start.
REQ-006 The block SHALL have port p, input, 32, the modulus; it is sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port result, output, 32, the almost-inverse a^-1 * 2^k mod p.
REQ-010 The block SHALL have port k, output, 7, the iteration count.
REQ-011 The block SHALL have port err, output, 1, which flags invalid operands or no inverse; it is valid when done=1.

Function
REQ-012 The block SHALL implement the FSM states IDLE, LOAD, ITER, FIX and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a and p and go to LOAD; start SHALL be ignored in all other states.
REQ-014 In LOAD, the block SHALL check operand validity:
- Operands are invalid if p[0]=0, a=0, or a>=p.
- Invalid operands SHALL go to DONE with err=1, result=0 and k=0.
- Valid operands SHALL initialise u=p, v=a, r=0, s=1, k=0 and go to ITER.
REQ-015 Internal registers SHALL be sized as u,v 32 bits, r,s 33 bits and the iteration count 7 bits; r+s SHALL never be truncated.
REQ-016 ITER SHALL perform one step per cycle. If v=0, the block SHALL go to FIX with no state change. Otherwise, in priority order:
- u even: u=u>>1, s=s<<1.
- Else v even: v=v>>1, r=r<<1.
- Else u>v: u=(u-v)>>1, r=r+s, s=s<<1.
- Else: v=(v-u)>>1, s=s+r, r=r<<1.
- Every step SHALL increment k by 1.
REQ-017 The u>v decision SHALL be taken from the gt output of an instance of compare_32bit with a=u and b=v.
REQ-018 FIX SHALL register the outputs and go to DONE:
- If u!=1, then err=1 and result=0.
- Else if r>=p, then result=2p-r and err=0.
- Else result=p-r and err=0.
- In all cases, output k SHALL take the iteration count.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-020 Latency SHALL be measured from the edge that samples start:
- For a valid operand pair, done SHALL be high after edge k+3.
- For invalid operands, done SHALL be high after edge 2.
REQ-021 For valid coprime operands, 32<=k<=64 SHALL hold whenever p>=2^31; k SHALL never exceed 64.
REQ-022 result, k and err SHALL hold their values from DONE until the next LOAD.
REQ-023 A start in the same cycle as done SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-024 When rst_n=0, the block SHALL immediately force state to IDLE and set busy=0, done=0, result=0, k=0 and err=0, regardless of clk.
REQ-025 The block SHALL clear all internal registers (u, v, r, s, count, latched a and p) to 0 on reset.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover p=7, a=3 -> result=3, k=4, err=0, done after edge 7; check 3*5*... i.e. 5*16 mod 7=3.
REQ-028 The bench SHALL cover p=7, a=1 -> result=1, k=3, err=0, done after edge 6.
REQ-029 The bench SHALL cover p=9, a=3 (gcd 3) -> err=1, result=0, k=2, done after edge 5.
REQ-030 The bench SHALL cover the invalid cases p=6 a=1, p=7 a=0 and p=7 a=7 -> each gives err=1, result=0, k=0, done after edge 2.
REQ-031 The bench SHALL cover start pulsed while busy during the p=7, a=3 run -> the second start is ignored and a single done arrives with result=3.
REQ-032 The bench SHALL cover rst_n pulled low at edge 4 of the p=7, a=3 run -> all outputs read 0 immediately, no done follows, and a fresh start gives result=3, k=4.
REQ-033 The bench SHALL run a random scoreboard with odd p>=2^31 and a in [1,p-1] against a reference model, checking result*a ≡ 2^k (mod p) when gcd=1 and 32<=k<=64.
